// File: rtl/config_sequence_controller.sv
// Handshaked configuration sequencer: steps through NUM_STEPS go/done pairs,
// repeats a loop region until released, then runs a clear phase before completion.
module config_sequence_controller #(
  parameter int unsigned NUM_STEPS  = 10,
  parameter int unsigned LOOP_FIRST = 2,
  parameter int unsigned LOOP_LAST  = 9,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned ITER_W     = 8
) (
  input  logic                 clk,
  input  logic                 program_reset,
  input  logic                 start_process,
  input  logic                 abort,
  input  logic [NUM_STEPS-1:0] step_done,
  input  logic                 loop_exit,
  input  logic                 signals_cleared,
  input  logic [TMO_W-1:0]     timeout_limit,
  output logic [NUM_STEPS-1:0] step_go,
  output logic                 go_clear_signals,
  output logic                 end_process,
  output logic                 error,
  output logic [4:0]           current_step,
  output logic [ITER_W-1:0]    iteration_count
);

  typedef enum logic [2:0] {
    S_RUN, S_CLEAR, S_DONE, S_ERROR, S_IDLE
  } state_t;

  localparam logic [4:0] LF_IDX   = 5'(LOOP_FIRST);
  localparam logic [4:0] LL_IDX   = 5'(LOOP_LAST);
  localparam logic [4:0] LAST_IDX = 5'(NUM_STEPS - 1);

  state_t           state;
  logic [TMO_W-1:0] watchdog;
  logic             cur_done;
  logic             advance;
  logic             to_clear;
  logic             wrap;
  logic [4:0]       next_step;
  logic             wd_expire;

  // Only the handshake bit of the active step is visible to the sequencer.
  always_comb begin
    cur_done = 1'b0;
    for (int unsigned k = 0; k < NUM_STEPS; k++) begin
      if (current_step == 5'(k)) cur_done = step_done[k];
    end
  end

  // Loop_exit at LOOP_FIRST is checked ahead of the LOOP_LAST wrap so that a
  // single-step loop region still honours it.
  always_comb begin
    advance   = 1'b0;
    to_clear  = 1'b0;
    wrap      = 1'b0;
    next_step = current_step + 5'd1;
    if (current_step == '0) begin
      advance = cur_done && start_process;
    end else if (current_step == LF_IDX && loop_exit) begin
      advance  = 1'b1;
      to_clear = 1'b1;
    end else if (current_step == LL_IDX) begin
      advance   = cur_done;
      wrap      = 1'b1;
      next_step = LF_IDX;
    end else if (current_step == LAST_IDX) begin
      advance  = cur_done;
      to_clear = 1'b1;
    end else begin
      advance = cur_done;
    end
  end

  assign wd_expire = (timeout_limit != '0) && (watchdog == timeout_limit - TMO_W'(1));

  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state           <= S_RUN;
      current_step    <= '0;
      iteration_count <= '0;
      watchdog        <= '0;
    end else if (abort) begin
      state        <= S_IDLE;
      current_step <= '0;
      watchdog     <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (advance) begin
            watchdog <= '0;
            if (to_clear) begin
              state        <= S_CLEAR;
              current_step <= '0;
            end else begin
              current_step <= next_step;
              if (wrap && iteration_count != '1)
                iteration_count <= iteration_count + ITER_W'(1);
            end
          end else if (wd_expire) begin
            state        <= S_ERROR;
            current_step <= '0;
            watchdog     <= '0;
          end else begin
            watchdog <= watchdog + TMO_W'(1);
          end
        end
        S_CLEAR: begin
          watchdog <= '0;
          if (signals_cleared) state <= S_DONE;
        end
        S_DONE, S_ERROR: begin
          watchdog <= '0;
          if (!start_process) state <= S_IDLE;
        end
        S_IDLE: begin
          watchdog <= '0;
          if (start_process) begin
            state           <= S_RUN;
            current_step    <= '0;
            iteration_count <= '0;
          end
        end
        default: begin
          state        <= S_IDLE;
          current_step <= '0;
          watchdog     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    step_go = '0;
    for (int unsigned k = 0; k < NUM_STEPS; k++) begin
      if (state == S_RUN && current_step == 5'(k)) step_go[k] = 1'b1;
    end
    go_clear_signals = (state == S_CLEAR);
    end_process      = (state == S_DONE);
    error            = (state == S_ERROR);
  end

endmodule

// File: tb/tb_config_sequence_controller.sv
// Directed bench for config_sequence_controller; a second instance with a
// 2-bit iteration counter shares the stimulus to exercise saturation.
module tb_config_sequence_controller;

  localparam int unsigned NS = 10;

  logic          clk = 1'b0;
  logic          program_reset;
  logic          start_process;
  logic          abort;
  logic [NS-1:0] step_done;
  logic          loop_exit;
  logic          signals_cleared;
  logic [15:0]   timeout_limit;

  logic [NS-1:0] step_go,  step_go2;
  logic          go_clear, go_clear2;
  logic          end_proc, end_proc2;
  logic          err,      err2;
  logic [4:0]    cur_step, cur_step2;
  logic [7:0]    iter;
  logic [1:0]    iter2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  config_sequence_controller #(
    .NUM_STEPS(NS), .LOOP_FIRST(2), .LOOP_LAST(9), .TMO_W(16), .ITER_W(8)
  ) dut (
    .clk(clk), .program_reset(program_reset), .start_process(start_process),
    .abort(abort), .step_done(step_done), .loop_exit(loop_exit),
    .signals_cleared(signals_cleared), .timeout_limit(timeout_limit),
    .step_go(step_go), .go_clear_signals(go_clear), .end_process(end_proc),
    .error(err), .current_step(cur_step), .iteration_count(iter)
  );

  config_sequence_controller #(
    .NUM_STEPS(NS), .LOOP_FIRST(2), .LOOP_LAST(9), .TMO_W(16), .ITER_W(2)
  ) dut_sat (
    .clk(clk), .program_reset(program_reset), .start_process(start_process),
    .abort(abort), .step_done(step_done), .loop_exit(loop_exit),
    .signals_cleared(signals_cleared), .timeout_limit(timeout_limit),
    .step_go(step_go2), .go_clear_signals(go_clear2), .end_process(end_proc2),
    .error(err2), .current_step(cur_step2), .iteration_count(iter2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned k);
    step_done    = '0;
    step_done[k] = 1'b1;
    tick();
    step_done = '0;
  endtask

  task automatic pulse_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned k = lo; k <= hi; k++) pulse(k);
  endtask

  task automatic finish_clear_phase();
    signals_cleared = 1'b1;
    tick();
    signals_cleared = 1'b0;
    start_process   = 1'b0;
    tick();
  endtask

  initial begin
    program_reset   = 1'b1;
    start_process   = 1'b0;
    abort           = 1'b0;
    step_done       = '0;
    loop_exit       = 1'b0;
    signals_cleared = 1'b0;
    timeout_limit   = '0;

    // Reset asserted before any clock edge.
    #3;
    check("rst_step_go", 32'(step_go), 32'h1);
    check("rst_step", 32'(cur_step), 32'd0);
    check("rst_flags", {29'd0, go_clear, end_proc, err}, 32'd0);
    check("rst_iter", 32'(iter), 32'd0);
    tick();
    tick();
    program_reset = 1'b0;

    // done[0] without start is held off.
    step_done[0] = 1'b1;
    repeat (5) tick();
    check("gate_hold", 32'(cur_step), 32'd0);
    start_process = 1'b1;
    tick();
    step_done = '0;
    check("gate_go_step", 32'(cur_step), 32'd1);
    check("gate_go_strobe", 32'(step_go), 32'h2);

    // Two trips round the loop, then exit from step 2.
    pulse_range(1, 9);
    check("loop1_step", 32'(cur_step), 32'd2);
    check("loop1_iter", 32'(iter), 32'd1);
    pulse_range(2, 9);
    check("loop2_step", 32'(cur_step), 32'd2);
    check("loop2_iter", 32'(iter), 32'd2);
    loop_exit = 1'b1;
    tick();
    loop_exit = 1'b0;
    check("clear_req", 32'(go_clear), 32'd1);
    check("clear_no_go", 32'(step_go), 32'd0);
    tick();
    check("clear_hold", 32'(go_clear), 32'd1);
    signals_cleared = 1'b1;
    tick();
    signals_cleared = 1'b0;
    check("done_end", {30'd0, end_proc, go_clear}, 32'h2);
    tick();
    check("done_hold", 32'(end_proc), 32'd1);
    start_process = 1'b0;
    tick();
    check("idle_outs", {20'd0, step_go, go_clear, end_proc}, 32'd0);
    check("idle_iter_kept", 32'(iter), 32'd2);

    // Restart clears the count; loop_exit beats done[2]; stray done ignored.
    start_process = 1'b1;
    tick();
    check("restart_step", 32'(cur_step), 32'd0);
    check("restart_iter", 32'(iter), 32'd0);
    pulse_range(0, 3);
    check("at_step4", 32'(cur_step), 32'd4);
    pulse(5);
    check("stray_done", 32'(cur_step), 32'd4);
    pulse_range(4, 9);
    check("back_to_2", 32'(cur_step), 32'd2);
    step_done[2] = 1'b1;
    loop_exit    = 1'b1;
    tick();
    step_done = '0;
    loop_exit = 1'b0;
    check("exit_prio_clear", 32'(go_clear), 32'd1);
    check("exit_prio_go", 32'(step_go), 32'd0);
    finish_clear_phase();

    // Five iterations: the 2-bit counter saturates.
    start_process = 1'b1;
    tick();
    pulse_range(0, 1);
    for (int i = 0; i < 5; i++) pulse_range(2, 9);
    check("iter_wide", 32'(iter), 32'd5);
    check("iter_sat", 32'(iter2), 32'd3);
    check("iter_sat_step", 32'(cur_step2), 32'd2);
    loop_exit = 1'b1;
    tick();
    loop_exit = 1'b0;
    finish_clear_phase();

    // Watchdog expiry on step 3.
    start_process = 1'b1;
    timeout_limit = 16'd4;
    tick();
    pulse_range(0, 2);
    repeat (3) tick();
    check("wd_pre_step", 32'(cur_step), 32'd3);
    check("wd_pre_err", 32'(err), 32'd0);
    tick();
    check("wd_err", 32'(err), 32'd1);
    check("wd_err_sat", 32'(err2), 32'd1);
    check("wd_err_no_go", 32'(step_go), 32'd0);
    tick();
    check("wd_err_hold", 32'(err), 32'd1);
    start_process = 1'b0;
    tick();
    check("wd_idle", {31'd0, err}, 32'd0);

    // Advance on the expiry cycle wins, then abort from step 6.
    start_process = 1'b1;
    tick();
    pulse(0);
    repeat (3) tick();
    pulse(1);
    check("wd_race_step", 32'(cur_step), 32'd2);
    check("wd_race_err", 32'(err), 32'd0);
    pulse_range(2, 5);
    check("at_step6", 32'(step_go), 32'h40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", {19'd0, step_go, go_clear, end_proc, err}, 32'd0);
    timeout_limit = '0;
    tick();
    check("abort_restart", 32'(step_go), 32'h1);

    // Asynchronous reset mid step 7.
    pulse_range(0, 6);
    check("at_step7", 32'(cur_step), 32'd7);
    #2;
    program_reset = 1'b1;
    #1;
    check("async_rst_go", 32'(step_go), 32'h1);
    check("async_rst_step", 32'(cur_step), 32'd0);
    tick();
    program_reset = 1'b0;
    tick();
    check("post_rst_step", 32'(cur_step), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/config_sequence_controller.md
CONFIG_SEQUENCE_CONTROLLER -- requirements
Module: config_sequence_controller

Interface
REQ-001 Parameter NUM_STEPS, default 10: number of handshaked steps, 2..32.
REQ-002 Parameter LOOP_FIRST, default 2: first step of the repeating loop region, 1..NUM_STEPS-1.
REQ-003 Parameter LOOP_LAST, default 9: last step of the loop region, LOOP_FIRST..NUM_STEPS-1.
REQ-004 Parameter TMO_W, default 16: watchdog counter width.
REQ-005 Parameter ITER_W, default 8: iteration counter width.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 program_reset  input  1  asynchronous, active-high reset.
REQ-008 start_process  input  1  level request to run the sequence.
REQ-009 abort  input  1  synchronous abort request.
REQ-010 step_done  input  NUM_STEPS  per-step completion handshake.
REQ-011 loop_exit  input  1  no further loop work; sampled only at step LOOP_FIRST.
REQ-012 signals_cleared  input  1  clear-phase completion handshake.
REQ-013 timeout_limit  input  TMO_W  per-step cycle budget; 0 disables the watchdog.
REQ-014 step_go  output  NUM_STEPS  one-hot go strobe for the active step.
REQ-015 go_clear_signals  output  1  clear-phase request.
REQ-016 end_process  output  1  sequence complete.
REQ-017 error  output  1  watchdog expiry flag.
REQ-018 current_step  output  5  index of the active step.
REQ-019 iteration_count  output  ITER_W  completed loop iterations.

Function
REQ-020 The states SHALL be RUN, CLEAR, DONE, ERROR and IDLE, with a 5-bit step index valid in RUN.
REQ-021 step_go[k] SHALL be 1 only in RUN with current_step==k, decoded combinationally from registered state; all other bits are 0.
REQ-022 go_clear_signals SHALL be 1 only in CLEAR; end_process only in DONE; error only in ERROR.
REQ-023 RUN step 0 SHALL advance to step 1 only when step_done[0] and start_process are both 1 in the same cycle.
REQ-024 RUN step LOOP_FIRST SHALL go to CLEAR when loop_exit=1, which takes priority over step_done; otherwise it advances to the next step on step_done[LOOP_FIRST].
REQ-025 RUN step LOOP_LAST on step_done SHALL return to LOOP_FIRST and increment iteration_count, saturating at all-ones.
REQ-026 Any other RUN step k on step_done[k] SHALL go to k+1, or to CLEAR if k==NUM_STEPS-1.
REQ-027 step_done bits other than step_done[current_step] SHALL be ignored.
REQ-028 The watchdog SHALL clear on every state or step change and increment each cycle in RUN.
REQ-029 When timeout_limit!=0 and the watchdog equals timeout_limit-1 with no advance that cycle, the next state SHALL be ERROR; an advance in the same cycle wins.
REQ-030 CLEAR SHALL go to DONE on signals_cleared.
REQ-031 DONE SHALL hold while start_process=1 and go to IDLE when start_process=0.
REQ-032 ERROR SHALL hold while start_process=1 and go to IDLE when start_process=0.
REQ-033 IDLE SHALL go to RUN step 0 when start_process=1 and clear iteration_count on that transition.
REQ-034 abort=1 SHALL force IDLE next cycle from any state, overriding all other transitions.
REQ-035 Each transition SHALL take exactly one clock edge, so go strobes change on the edge after the qualifying done.

Reset
REQ-036 program_reset=1 SHALL immediately, without waiting for a clock, force RUN step 0, iteration_count=0 and watchdog=0.
REQ-037 During reset the outputs SHALL be step_go=1 (bit 0 only), current_step=0, and go_clear_signals=end_process=error=0.
REQ-038 Reset asserted mid-sequence SHALL discard all progress, with no partial handshake retained.

Verification
REQ-039 Defaults, timeout_limit=0: start=1, done[0]=1, then pulse done[1..9] twice, then loop_exit at step 2 -> CLEAR, iteration_count=2; signals_cleared -> end_process=1 until start=0 -> IDLE.
REQ-040 done[0]=1 with start=0 for 5 cycles -> current_step stays 0; raising start -> step 1 on the next edge.
REQ-041 timeout_limit=4 with step 3 never done -> error=1 exactly 4 cycles after entering step 3; start=0 -> IDLE.
REQ-042 At step 2, loop_exit=1 and done[2]=1 together -> CLEAR, not step 3; done[5] pulsed at step 4 -> no advance.
REQ-043 ITER_W=2, 5 loop iterations -> iteration_count saturates at 3.
REQ-044 Reset asynchronously mid-step 7 -> step_go=0x001 before the next edge; abort at step 6 -> IDLE, all go outputs 0.
